xintf_write_scheduler: RTL

XINTF_WRITE_SCHEDULER -- requirements
Module: xintf_write_scheduler

---
 rtl/mps_xintf_pkg.sv | 28 ++
 rtl/xintf_hs_timer.sv | 28 ++
 rtl/xintf_write_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mps_xintf_pkg.sv
// Shared definitions for the XINTF DPBRAM write scheduler: state encoding,
// grant codes, default base addresses and the halfword address helper.
package mps_xintf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_WR_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_HS    = 3'd4
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_SP   = 2'b01;
  localparam logic [1:0] GNT_CFG  = 2'b10;

  localparam logic [8:0] SP_BASE_DEF  = 9'h000;
  localparam logic [8:0] CFG_BASE_DEF = 9'h010;

  localparam int SP_WORDS = 2;

  // Word k occupies halfwords base+2k (low) and base+2k+1 (high).
  function automatic logic [8:0] hw_addr(input logic [8:0] base, input logic [7:0] word,
                                         input logic hi);
    return base + {word, hi};
  endfunction

endpackage

// File: rtl/xintf_hs_timer.sv
// Handshake wait timer: cleared on load, counts while enabled, flags expiry on
// the LIMIT-th counted cycle.
module xintf_hs_timer #(
  parameter int LIMIT = 1000,
  localparam int CW = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= '0;
    end else if (i_count && (cnt_q != CW'(LIMIT - 1))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign o_expire = i_count && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/xintf_write_scheduler.sv
// Arbitrates setpoint/config frame requests and streams each frame into the
// DPBRAM as halfwords, then handshakes completion with the DSP.
module xintf_write_scheduler
  import mps_xintf_pkg::*;
#(
  parameter int         CFG_WORDS  = 16,
  parameter logic [8:0] SP_BASE    = SP_BASE_DEF,
  parameter logic [8:0] CFG_BASE   = CFG_BASE_DEF,
  parameter int         HS_TIMEOUT = 1000,
  localparam int IDX_W = (CFG_WORDS > 2) ? $clog2(CFG_WORDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sp_req,
  input  logic [31:0]       i_set_c,
  input  logic [31:0]       i_set_v,
  input  logic              i_cfg_req,
  output logic [IDX_W-1:0]  o_cfg_idx,
  input  logic [31:0]       i_cfg_data,
  output logic [8:0]        o_xintf_addr,
  output logic              o_xintf_ce,
  output logic [15:0]       o_xintf_din,
  output logic              o_w_valid,
  input  logic              i_w_ready,
  output logic              o_busy,
  output logic [1:0]        o_grant,
  output logic              o_done,
  output logic              o_timeout
);

  state_e           state_q, state_d;
  logic             sp_pend_q, sp_pend_d, cfg_pend_q, cfg_pend_d;
  logic [1:0]       grant_q, grant_d, last_q, last_d, gnt_now;
  logic [IDX_W-1:0] word_q, word_d, idx_q, idx_d;
  logic [8:0]       addr_q, addr_d, base;
  logic [15:0]      din_q, din_d;
  logic             ce_q, ce_d, valid_q, valid_d, done_q, done_d, tmo_q, tmo_d;
  logic [31:0]      snap_c_q, snap_v_q, cur_word;
  logic             last_word, pend_any, hs_load, hs_expire;

  assign base      = (grant_q == GNT_CFG) ? CFG_BASE : SP_BASE;
  assign last_word = (grant_q == GNT_CFG) ? (word_q == IDX_W'(CFG_WORDS - 1))
                                          : (word_q == IDX_W'(SP_WORDS - 1));
  assign cur_word  = (grant_q == GNT_CFG) ? i_cfg_data : (word_q[0] ? snap_v_q : snap_c_q);
  assign pend_any  = sp_pend_q | cfg_pend_q | i_sp_req | i_cfg_req;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    word_d  = word_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ce_d    = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    hs_load = 1'b0;
    gnt_now = GNT_NONE;
    unique case (state_q)
      ST_IDLE: if (pend_any) state_d = ST_ARB;
      ST_ARB: begin
        // With both pending, the channel that did not win last time goes first.
        if (sp_pend_q && (!cfg_pend_q || (last_q != GNT_SP))) gnt_now = GNT_SP;
        else if (cfg_pend_q)                                   gnt_now = GNT_CFG;
        if (gnt_now == GNT_NONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_LO;
          grant_d = gnt_now;
          last_d  = gnt_now;
          word_d  = '0;
          idx_d   = '0;
          ce_d    = 1'b1;
          addr_d  = (gnt_now == GNT_CFG) ? CFG_BASE : SP_BASE;
          din_d   = (gnt_now == GNT_CFG) ? i_cfg_data[15:0] : i_set_c[15:0];
        end
      end
      ST_WR_LO: begin
        state_d = ST_WR_HI;
        ce_d    = 1'b1;
        addr_d  = hw_addr(base, 8'(word_q), 1'b1);
        din_d   = cur_word[31:16];
        // Advance the config index now so the next low half is ready a cycle early.
        if (grant_q == GNT_CFG) idx_d = last_word ? '0 : idx_q + IDX_W'(1);
      end
      ST_WR_HI: begin
        if (last_word) begin
          state_d = ST_HS;
          valid_d = 1'b1;
          hs_load = 1'b1;
        end else begin
          state_d = ST_WR_LO;
          word_d  = word_q + IDX_W'(1);
          ce_d    = 1'b1;
          addr_d  = hw_addr(base, 8'(word_q + IDX_W'(1)), 1'b0);
          din_d   = (grant_q == GNT_CFG) ? i_cfg_data[15:0] : snap_v_q[15:0];
        end
      end
      ST_HS: begin
        if (i_w_ready || hs_expire) begin
          done_d  = i_w_ready;
          tmo_d   = ~i_w_ready;
          grant_d = GNT_NONE;
          state_d = pend_any ? ST_ARB : ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sp_pend_d  = (sp_pend_q && (gnt_now != GNT_SP)) || i_sp_req;
    cfg_pend_d = (cfg_pend_q && (gnt_now != GNT_CFG)) || i_cfg_req;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      sp_pend_q  <= 1'b0;
      cfg_pend_q <= 1'b0;
      grant_q    <= GNT_NONE;
      last_q     <= GNT_NONE;
      word_q     <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      ce_q       <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_pend_q  <= sp_pend_d;
      cfg_pend_q <= cfg_pend_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ce_q       <= ce_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (gnt_now == GNT_SP) begin
      snap_c_q <= i_set_c;
      snap_v_q <= i_set_v;
    end
  end

  xintf_hs_timer #(.LIMIT(HS_TIMEOUT)) u_hs_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (hs_load),
    .i_count  (state_q == ST_HS),
    .o_expire (hs_expire)
  );

  assign o_cfg_idx    = idx_q;
  assign o_xintf_addr = addr_q;
  assign o_xintf_ce   = ce_q;
  assign o_xintf_din  = din_q;
  assign o_w_valid    = valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_grant      = grant_q;
  assign o_done       = done_q;
  assign o_timeout    = tmo_q;

endmodule
